// File: rtl/msg_decrypt_engine.sv
// Decrypter for LFSR-scrambled, parity-tagged messages. It recovers the seed and tap pattern
// from the space preamble, then writes the plaintext and the recovered settings back to DM.
module msg_decrypt_engine #(
   parameter int MSG_BASE  = 64,
   parameter int MSG_LEN   = 64,
   parameter int CHK_LEN   = 10,
   parameter int META_BASE = 61
) (
   input  logic       clk,
   input  logic       init,
   input  logic       req,
   output logic       ack,
   output logic       fail,
   output logic [6:0] par_err_cnt,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data
);

   typedef enum logic [2:0] {S_IDLE, S_SEED, S_SEARCH, S_DECODE, S_FILL, S_META, S_DONE} state_t;

   localparam logic [7:0] MSG_A   = 8'(MSG_BASE);
   localparam logic [7:0] META_A  = 8'(META_BASE);
   localparam logic [7:0] LAST_PT = 8'(META_BASE - 1);
   localparam logic [3:0] LAST_I  = 4'(CHK_LEN - 1);
   localparam logic [5:0] LAST_R  = 6'(MSG_LEN - 1);

   function automatic logic [6:0] tap_of(input logic [3:0] p);
      case (p)
         4'd0:    tap_of = 7'h60;
         4'd1:    tap_of = 7'h48;
         4'd2:    tap_of = 7'h78;
         4'd3:    tap_of = 7'h72;
         4'd4:    tap_of = 7'h6A;
         4'd5:    tap_of = 7'h69;
         4'd6:    tap_of = 7'h5C;
         4'd7:    tap_of = 7'h7E;
         4'd8:    tap_of = 7'h7B;
         default: tap_of = 7'h00;
      endcase
   endfunction

   function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] tap);
      lfsr_step = {s[5:0], ^(s & tap)};
   endfunction

   state_t     state_q, state_d;
   logic [6:0] s0_q, s0_d, s_q, s_d, pre_cnt_q, pre_cnt_d, par_q, par_d;
   logic [3:0] p_q, p_d, i_q, i_d;
   logic [5:0] r_q, r_d;
   logic [7:0] wptr_q, wptr_d, rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
   logic [1:0] m_q, m_d;
   logic       seen_q, seen_d, ack_q, ack_d, fail_q, fail_d, wr_en_q, wr_en_d;
   logic [6:0] s_next, pt;
   logic       par_bad;

   always_comb begin
      state_d   = state_q;
      s0_d      = s0_q;
      s_d       = s_q;
      pre_cnt_d = pre_cnt_q;
      par_d     = par_q;
      p_d       = p_q;
      i_d       = i_q;
      r_d       = r_q;
      wptr_d    = wptr_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      m_d       = m_q;
      seen_d    = seen_q;
      ack_d     = ack_q;
      fail_d    = fail_q;
      wr_en_d   = 1'b0;
      s_next    = lfsr_step(s_q, tap_of(p_q));
      pt        = rd_data[6:0] ^ s_q;
      par_bad   = rd_data[7] != (^rd_data[6:0]);
      case (state_q)
         S_IDLE: begin
            if (!req) begin
               state_d   = S_SEED;
               rd_addr_d = MSG_A;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SEED: begin
            s0_d      = rd_data[6:0] ^ 7'h20;
            s_d       = rd_data[6:0] ^ 7'h20;
            p_d       = 4'd0;
            i_d       = 4'd1;
            rd_addr_d = MSG_A + 8'd1;
            fail_d    = 1'b0;
            par_d     = 7'd0;
            wptr_d    = 8'd0;
            pre_cnt_d = 7'd0;
            seen_d    = 1'b0;
            state_d   = S_SEARCH;
         end
         S_SEARCH: begin
            if ((rd_data[6:0] ^ s_next) == 7'h20) begin
               if (i_q == LAST_I) begin
                  // Locked: rewind to the seed so DECODE replays the whole stream.
                  s_d       = s0_q;
                  r_d       = 6'd0;
                  rd_addr_d = MSG_A;
                  state_d   = S_DECODE;
               end else begin
                  s_d       = s_next;
                  i_d       = i_q + 4'd1;
                  rd_addr_d = rd_addr_q + 8'd1;
               end
            end else begin
               s_d       = s0_q;
               i_d       = 4'd1;
               rd_addr_d = MSG_A + 8'd1;
               if (p_q == 4'd8) begin
                  fail_d  = 1'b1;
                  ack_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  p_d = p_q + 4'd1;
               end
            end
         end
         S_DECODE: begin
            s_d = s_next;
            if (par_bad && (par_q != 7'h7F)) begin
               par_d = par_q + 7'd1;
            end else begin
               par_d = par_q;
            end
            if (!seen_q && (pt == 7'h20)) begin
               pre_cnt_d = pre_cnt_q + 7'd1;
            end else begin
               seen_d = 1'b1;
               wptr_d = wptr_q + 8'd1;
               if (wptr_q <= LAST_PT) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = wptr_q;
                  wr_data_d = {1'b0, pt};
               end else begin
                  wr_en_d = 1'b0;
               end
            end
            if (r_q == LAST_R) begin
               state_d = S_FILL;
            end else begin
               r_d       = r_q + 6'd1;
               rd_addr_d = rd_addr_q + 8'd1;
            end
         end
         S_FILL: begin
            m_d = 2'd0;
            if (wptr_q <= LAST_PT) begin
               wr_en_d   = 1'b1;
               wr_addr_d = wptr_q;
               wr_data_d = 8'h20;
               wptr_d    = wptr_q + 8'd1;
               if (wptr_q == LAST_PT) begin
                  state_d = S_META;
               end else begin
                  state_d = S_FILL;
               end
            end else begin
               state_d = S_META;
            end
         end
         S_META: begin
            wr_en_d = 1'b1;
            m_d     = m_q + 2'd1;
            case (m_q)
               2'd0: begin
                  wr_addr_d = META_A;
                  wr_data_d = {1'b0, pre_cnt_q};
               end
               2'd1: begin
                  wr_addr_d = META_A + 8'd1;
                  wr_data_d = {4'd0, p_q};
               end
               default: begin
                  wr_addr_d = META_A + 8'd2;
                  wr_data_d = {1'b0, s0_q};
                  ack_d     = 1'b1;
                  state_d   = S_DONE;
               end
            endcase
         end
         S_DONE: begin
            if (req) begin
               ack_d   = 1'b0;
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (init) begin
         state_q   <= S_IDLE;
         s0_q      <= 7'd0;
         s_q       <= 7'd0;
         pre_cnt_q <= 7'd0;
         par_q     <= 7'd0;
         p_q       <= 4'd0;
         i_q       <= 4'd0;
         r_q       <= 6'd0;
         wptr_q    <= 8'd0;
         rd_addr_q <= 8'd0;
         wr_addr_q <= 8'd0;
         wr_data_q <= 8'd0;
         m_q       <= 2'd0;
         seen_q    <= 1'b0;
         ack_q     <= 1'b0;
         fail_q    <= 1'b0;
         wr_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         s0_q      <= s0_d;
         s_q       <= s_d;
         pre_cnt_q <= pre_cnt_d;
         par_q     <= par_d;
         p_q       <= p_d;
         i_q       <= i_d;
         r_q       <= r_d;
         wptr_q    <= wptr_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         m_q       <= m_d;
         seen_q    <= seen_d;
         ack_q     <= ack_d;
         fail_q    <= fail_d;
         wr_en_q   <= wr_en_d;
      end
   end

   assign ack         = ack_q;
   assign fail        = fail_q;
   assign par_err_cnt = par_q;
   assign rd_addr     = rd_addr_q;
   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;

endmodule
